// File: rtl/ip_codma_bus_arbiter.sv
// Round-robin owner of the codma system-bus master port. Picks one requester,
// requests the fabric, counts data beats against the owner's size code, guards
// the burst with a watchdog and reports done/err back to the owner.
//
// Handshake: req_i[r] is a level request. It is held until the arbiter answers
// with a one-cycle done_o[r] or err_o[r] pulse, and is dropped in that pulse
// cycle. bus_req_o stays high until the fabric answers with bus_grant_i. After
// the grant, bus_beat_i marks one accepted or returned 64-bit beat per cycle.
// bus_beat_i is ignored outside the data phase. abort_i overrides everything
// and returns the arbiter to idle without a done or err pulse.
module ip_codma_bus_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 256
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 abort_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ*4-1:0] size_i,
  input  logic [NUM_REQ-1:0]   write_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [NUM_REQ-1:0]   done_o,
  output logic [NUM_REQ-1:0]   err_o,
  output logic                 timeout_o,
  output logic                 busy_o,
  output logic                 bus_req_o,
  output logic [3:0]           bus_size_o,
  output logic                 bus_write_o,
  input  logic                 bus_grant_i,
  input  logic                 bus_beat_i,
  input  logic                 bus_error_i,
  output logic [2:0]           dbg_state_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    ARB_IDLE = 3'd0,
    ARB_REQ  = 3'd1,
    ARB_XFER = 3'd2,
    ARB_DONE = 3'd3,
    ARB_ERR  = 3'd4
  } arb_state_t;

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, owner_q, owner_next;
  logic [IDX_W-1:0]   pick_idx, cand;
  logic               pick_vld;
  logic [3:0]         pick_size;
  logic [3:0]         size_q;
  logic               write_q;
  logic [2:0]         beat_q, beats_need;
  logic [WD_W-1:0]    wd_q;
  logic               timeout_q;
  logic               wd_hit, wd_expire, final_beat;
  logic [NUM_REQ-1:0] owner_oh;

  // Only three burst lengths exist on this port: 1, 3 or 4 beats.
  function automatic logic legal_size(input logic [3:0] s);
    return (s == 4'd3) || (s == 4'd8) || (s == 4'd9);
  endfunction

  // Round-robin search: first set request at or above ptr, wrapping around.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!pick_vld && req_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign pick_size  = size_i[{pick_idx, 2'b00} +: 4];
  assign owner_next = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign owner_oh   = NUM_REQ'(1) << owner_q;

  // Beats required by the latched size code.
  always_comb begin
    case (size_q)
      4'd3:    beats_need = 3'd1;
      4'd8:    beats_need = 3'd3;
      4'd9:    beats_need = 3'd4;
      default: beats_need = 3'd0;
    endcase
  end

  // Watchdog expiry only when no progress (grant or beat) arrives in the final cycle.
  always_comb begin
    wd_hit     = (wd_q == WD_W'(TIMEOUT - 1));
    final_beat = bus_beat_i && ((beat_q + 3'd1) == beats_need);
    wd_expire  = 1'b0;
    if (!abort_i && !bus_error_i && wd_hit) begin
      if (state_q == ARB_REQ)  wd_expire = !bus_grant_i;
      if (state_q == ARB_XFER) wd_expire = !bus_beat_i;
    end
  end

  // Next-state logic; precedence abort > bus error > watchdog > final beat > grant.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (pick_vld) state_d = legal_size(pick_size) ? ARB_REQ : ARB_ERR;
      ARB_REQ: begin
        if (bus_error_i)      state_d = ARB_ERR;
        else if (wd_expire)   state_d = ARB_ERR;
        else if (bus_grant_i) state_d = ARB_XFER;
      end
      ARB_XFER: begin
        if (bus_error_i)     state_d = ARB_ERR;
        else if (wd_expire)  state_d = ARB_ERR;
        else if (final_beat) state_d = ARB_DONE;
      end
      ARB_DONE: state_d = ARB_IDLE;
      ARB_ERR:  state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
    if (abort_i) state_d = ARB_IDLE;
  end

  // State, owner latch, round-robin pointer, beat counter, watchdog, sticky timeout.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      size_q    <= '0;
      write_q   <= 1'b0;
      beat_q    <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ARB_IDLE && pick_vld && !abort_i) begin
        owner_q <= pick_idx;
        size_q  <= pick_size;
        write_q <= write_i[pick_idx];
      end
      if ((state_q == ARB_DONE || state_q == ARB_ERR) && !abort_i) ptr_q <= owner_next;
      if (abort_i || state_q == ARB_REQ)         beat_q <= '0;
      else if (state_q == ARB_XFER && bus_beat_i) beat_q <= beat_q + 3'd1;
      if (abort_i || !(state_q == ARB_REQ || state_q == ARB_XFER)) wd_q <= '0;
      else if (state_q == ARB_REQ && bus_grant_i)                 wd_q <= '0;
      else if (state_q == ARB_XFER && bus_beat_i)                 wd_q <= '0;
      else                                                        wd_q <= wd_q + 1'b1;
      if (wd_expire) timeout_q <= 1'b1;
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    grant_o     = (state_q == ARB_XFER) ? owner_oh : '0;
    done_o      = (state_q == ARB_DONE) ? owner_oh : '0;
    err_o       = (state_q == ARB_ERR)  ? owner_oh : '0;
    bus_req_o   = (state_q == ARB_REQ) || (state_q == ARB_XFER);
    busy_o      = (state_q != ARB_IDLE);
    timeout_o   = timeout_q;
    bus_size_o  = size_q;
    bus_write_o = write_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_ip_codma_bus_arbiter.sv
// Directed bench for ip_codma_bus_arbiter: reset, round-robin order, single
// read with a beat gap, bus error, illegal size, watchdog timeout and abort.
module tb_ip_codma_bus_arbiter;

  localparam int NUM_REQ = 3;
  localparam int TIMEOUT = 8;

  logic                 clk_i = 1'b0;
  logic                 reset_n_i;
  logic                 abort_i;
  logic [NUM_REQ-1:0]   req_i;
  logic [NUM_REQ*4-1:0] size_i;
  logic [NUM_REQ-1:0]   write_i;
  logic [NUM_REQ-1:0]   grant_o, done_o, err_o;
  logic                 timeout_o, busy_o, bus_req_o, bus_write_o;
  logic [3:0]           bus_size_o;
  logic                 bus_grant_i, bus_beat_i, bus_error_i;
  logic [2:0]           dbg_state_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Clock
  always #5 clk_i = ~clk_i;

  ip_codma_bus_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .abort_i(abort_i),
    .req_i(req_i), .size_i(size_i), .write_i(write_i),
    .grant_o(grant_o), .done_o(done_o), .err_o(err_o),
    .timeout_o(timeout_o), .busy_o(busy_o), .bus_req_o(bus_req_o),
    .bus_size_o(bus_size_o), .bus_write_o(bus_write_o),
    .bus_grant_i(bus_grant_i), .bus_beat_i(bus_beat_i), .bus_error_i(bus_error_i),
    .dbg_state_o(dbg_state_o)
  );

  // Advance one cycle; outputs are sampled and inputs driven 1 ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_size(input int r, input logic [3:0] s);
    size_i[r*4 +: 4] = s;
  endtask

  // One complete burst: REQ, grant, nbeats back-to-back, DONE, IDLE.
  task automatic run_burst(input int exp_owner, input int nbeats, input logic [2:0] req_after);
    logic [2:0] oh;
    oh = 3'b001 << exp_owner;
    tick();
    n_cmp++; if ({bus_req_o, grant_o} !== 4'b1000) begin n_bad++; $display("FAIL burst_req owner=%0d got=%b exp=1000", exp_owner, {bus_req_o, grant_o}); end
    bus_grant_i = 1'b1;
    tick();
    bus_grant_i = 1'b0;
    n_cmp++; if (grant_o !== oh) begin n_bad++; $display("FAIL burst_grant got=%b exp=%b", grant_o, oh); end
    for (int i = 0; i < nbeats; i++) begin
      bus_beat_i = 1'b1;
      tick();
      if (i < nbeats - 1) begin
        n_cmp++; if (grant_o !== oh) begin n_bad++; $display("FAIL burst_grant_hold got=%b exp=%b", grant_o, oh); end
      end
    end
    bus_beat_i = 1'b0;
    n_cmp++; if (done_o !== oh) begin n_bad++; $display("FAIL burst_done got=%b exp=%b", done_o, oh); end
    n_cmp++; if ({grant_o, bus_req_o, err_o} !== 7'b0) begin n_bad++; $display("FAIL burst_done_quiet got=%b exp=0", {grant_o, bus_req_o, err_o}); end
    req_i = req_after;
    tick();
    n_cmp++; if ({done_o, busy_o} !== 4'b0) begin n_bad++; $display("FAIL burst_idle got=%b exp=0000", {done_o, busy_o}); end
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0; abort_i = 1'b0; req_i = '0; size_i = '0; write_i = '0;
    bus_grant_i = 1'b0; bus_beat_i = 1'b0; bus_error_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    n_cmp++; if ({grant_o, done_o, err_o} !== 9'b0) begin n_bad++; $display("FAIL reset_pulses got=%b exp=0", {grant_o, done_o, err_o}); end
    n_cmp++; if ({timeout_o, busy_o, bus_req_o, bus_write_o} !== 4'b0) begin n_bad++; $display("FAIL reset_flags got=%b exp=0000", {timeout_o, busy_o, bus_req_o, bus_write_o}); end
    n_cmp++; if (bus_size_o !== 4'd0) begin n_bad++; $display("FAIL reset_size got=%0d exp=0", bus_size_o); end
    n_cmp++; if (dbg_state_o !== 3'd0) begin n_bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state_o); end
    reset_n_i = 1'b1;
    tick();
  endtask

  // Owners 0,1,2,0 from ptr 0, then 1,2,0 from ptr 1, every requester re-raising.
  task automatic test_round_robin();
    int seq[7] = '{0, 1, 2, 0, 1, 2, 0};
    for (int r = 0; r < NUM_REQ; r++) set_size(r, 4'd3);
    req_i = 3'b111;
    for (int k = 0; k < 7; k++) run_burst(seq[k], 1, (k == 6) ? 3'b000 : 3'b111);
  endtask

  // Size 9 read on requester 1, grant after 2 cycles, 4 beats with one gap.
  task automatic test_single_read();
    logic pat[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    set_size(1, 4'd9); write_i = 3'b000; req_i = 3'b010;
    tick();
    n_cmp++; if (bus_req_o !== 1'b1) begin n_bad++; $display("FAIL read_bus_req got=%b exp=1", bus_req_o); end
    n_cmp++; if ({bus_size_o, bus_write_o} !== 5'b1001_0) begin n_bad++; $display("FAIL read_attr got=%b exp=10010", {bus_size_o, bus_write_o}); end
    tick();
    n_cmp++; if ({bus_req_o, grant_o} !== 4'b1000) begin n_bad++; $display("FAIL read_wait got=%b exp=1000", {bus_req_o, grant_o}); end
    bus_grant_i = 1'b1;
    tick();
    bus_grant_i = 1'b0;
    n_cmp++; if (grant_o !== 3'b010) begin n_bad++; $display("FAIL read_grant got=%b exp=010", grant_o); end
    for (int j = 0; j < 5; j++) begin
      bus_beat_i = pat[j];
      tick();
      if (j < 4) begin
        n_cmp++; if ({grant_o, done_o} !== 6'b010_000) begin n_bad++; $display("FAIL read_data_phase beat=%0d got=%b exp=010000", j, {grant_o, done_o}); end
      end
    end
    bus_beat_i = 1'b0;
    n_cmp++; if ({done_o, busy_o, grant_o} !== 7'b010_1_000) begin n_bad++; $display("FAIL read_done got=%b exp=0101000", {done_o, busy_o, grant_o}); end
    req_i = 3'b000;
    tick();
    n_cmp++; if ({busy_o, done_o} !== 4'b0) begin n_bad++; $display("FAIL read_idle got=%b exp=0000", {busy_o, done_o}); end
  endtask

  // Size 8 write by requester 2 errors on beat 2; next search starts at 0.
  task automatic test_bus_error();
    set_size(2, 4'd8); write_i = 3'b100; req_i = 3'b100;
    tick();
    n_cmp++; if ({bus_req_o, bus_size_o, bus_write_o} !== 6'b1_1000_1) begin n_bad++; $display("FAIL err_attr got=%b exp=110001", {bus_req_o, bus_size_o, bus_write_o}); end
    bus_grant_i = 1'b1;
    tick();
    bus_grant_i = 1'b0; bus_beat_i = 1'b1;
    tick();
    bus_error_i = 1'b1;
    tick();
    bus_beat_i = 1'b0; bus_error_i = 1'b0;
    n_cmp++; if (err_o !== 3'b100) begin n_bad++; $display("FAIL err_pulse got=%b exp=100", err_o); end
    n_cmp++; if ({done_o, grant_o, bus_req_o, timeout_o} !== 8'b0) begin n_bad++; $display("FAIL err_quiet got=%b exp=0", {done_o, grant_o, bus_req_o, timeout_o}); end
    req_i = 3'b000;
    tick();
    n_cmp++; if ({err_o, busy_o} !== 4'b0) begin n_bad++; $display("FAIL err_one_cycle got=%b exp=0000", {err_o, busy_o}); end
    set_size(0, 4'd3); set_size(2, 4'd3); write_i = 3'b000; req_i = 3'b101;
    run_burst(0, 1, 3'b000);
  endtask

  // Size 5 on requester 0 goes straight to error, never requesting the fabric.
  task automatic test_illegal_size();
    set_size(0, 4'd5); req_i = 3'b001;
    tick();
    n_cmp++; if (err_o !== 3'b001) begin n_bad++; $display("FAIL illegal_err got=%b exp=001", err_o); end
    n_cmp++; if (bus_req_o !== 1'b0) begin n_bad++; $display("FAIL illegal_bus_req got=%b exp=0", bus_req_o); end
    n_cmp++; if (dbg_state_o !== 3'd4) begin n_bad++; $display("FAIL illegal_state got=%0d exp=4", dbg_state_o); end
    req_i = 3'b000;
    tick();
    n_cmp++; if ({err_o, bus_req_o, busy_o} !== 5'b0) begin n_bad++; $display("FAIL illegal_after got=%b exp=0", {err_o, bus_req_o, busy_o}); end
  endtask

  // Grant withheld: err and timeout exactly TIMEOUT cycles after bus_req_o rises.
  task automatic test_timeout();
    set_size(1, 4'd3); req_i = 3'b010;
    tick();
    n_cmp++; if (bus_req_o !== 1'b1) begin n_bad++; $display("FAIL to_req got=%b exp=1", bus_req_o); end
    for (int j = 1; j < TIMEOUT; j++) begin
      tick();
      n_cmp++; if ({bus_req_o, err_o, timeout_o} !== 5'b1_000_0) begin n_bad++; $display("FAIL to_wait cyc=%0d got=%b exp=10000", j, {bus_req_o, err_o, timeout_o}); end
    end
    tick();
    n_cmp++; if ({err_o, timeout_o, bus_req_o} !== 5'b010_1_0) begin n_bad++; $display("FAIL to_expire got=%b exp=01010", {err_o, timeout_o, bus_req_o}); end
    req_i = 3'b000;
    tick();
    n_cmp++; if ({timeout_o, bus_req_o, err_o} !== 5'b1_0_000) begin n_bad++; $display("FAIL to_sticky got=%b exp=10000", {timeout_o, bus_req_o, err_o}); end
  endtask

  // Abort with the final beat: idle next cycle, no pulses, ptr stays at 2.
  task automatic test_abort();
    set_size(2, 4'd3); req_i = 3'b100;
    tick();
    bus_grant_i = 1'b1;
    tick();
    bus_grant_i = 1'b0;
    n_cmp++; if (grant_o !== 3'b100) begin n_bad++; $display("FAIL abort_grant got=%b exp=100", grant_o); end
    bus_beat_i = 1'b1; abort_i = 1'b1; req_i = 3'b000;
    tick();
    bus_beat_i = 1'b0; abort_i = 1'b0;
    n_cmp++; if (dbg_state_o !== 3'd0) begin n_bad++; $display("FAIL abort_state got=%0d exp=0", dbg_state_o); end
    n_cmp++; if ({done_o, err_o, grant_o, bus_req_o, busy_o} !== 11'b0) begin n_bad++; $display("FAIL abort_quiet got=%b exp=0", {done_o, err_o, grant_o, bus_req_o, busy_o}); end
    n_cmp++; if (timeout_o !== 1'b1) begin n_bad++; $display("FAIL abort_timeout_kept got=%b exp=1", timeout_o); end
    tick();
    n_cmp++; if ({done_o, err_o} !== 6'b0) begin n_bad++; $display("FAIL abort_no_late_pulse got=%b exp=0", {done_o, err_o}); end
    for (int r = 0; r < NUM_REQ; r++) set_size(r, 4'd3);
    req_i = 3'b111;
    run_burst(2, 1, 3'b000);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_read();
    test_bus_error();
    test_illegal_size();
    test_timeout();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
